// File: rtl/regfile_clr.sv
// regfile_clr: 2R1W register file with a hardware clear sequence after reset.
// r0 is hardwired to zero, reads are combinational with write-through bypass,
// and storage carries no reset flops -- a counter walks every word to zero instead.

// One read port: gating, bypass and array read for a single lane.
module regfile_clr_rdport #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic [REG_DATA_WIDTH-1:0] mem_word,
  input  logic                      blank,
  input  logic                      wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [REG_DATA_WIDTH-1:0] wr_data,
  output logic [REG_DATA_WIDTH-1:0] rd_data
);

  // Zero when disabled, r0, or the array is not yet valid; else bypass or array word.
  always_comb begin
    rd_data = '0;
    if (blank || !rd_en || rd_addr == '0)
      rd_data = '0;
    else if (wr_en && wr_addr == rd_addr)
      rd_data = wr_data;
    else
      rd_data = mem_word;
  end

endmodule

module regfile_clr #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [REG_DATA_WIDTH-1:0] wr_data,
  input  logic                      rd_en1,
  input  logic                      rd_en2,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr1,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr2,
  output logic [REG_DATA_WIDTH-1:0] rd_data1,
  output logic [REG_DATA_WIDTH-1:0] rd_data2,
  output logic                      init_busy
);

  localparam int DEPTH  = 1 << REG_ADDR_WIDTH;
  localparam int NUM_RD = 2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                    state;
  logic [REG_ADDR_WIDTH-1:0] clr_cnt;
  logic [REG_DATA_WIDTH-1:0] mem [DEPTH];

  logic [NUM_RD-1:0]                     rd_en_v;
  logic [NUM_RD-1:0][REG_ADDR_WIDTH-1:0] rd_addr_v;
  logic [NUM_RD-1:0][REG_DATA_WIDTH-1:0] mem_word_v;
  logic [NUM_RD-1:0][REG_DATA_WIDTH-1:0] rd_data_v;
  logic                                  blank;

  // rst is folded in so reads are zero before the first reset edge lands.
  assign blank = rst | init_busy;

  // Clear-sequence control; init_busy is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == '1) begin
        state     <= READY;
        init_busy <= 1'b0;
      end
    end
  end

  // Storage: clear walk has priority; functional writes only in READY, never r0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[clr_cnt] <= '0;
      else if (wr_en && wr_addr != '0)
        mem[wr_addr] <= wr_data;
    end
  end

  assign rd_en_v   = {rd_en2, rd_en1};
  assign rd_addr_v = {rd_addr2, rd_addr1};
  assign rd_data1  = rd_data_v[0];
  assign rd_data2  = rd_data_v[1];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign mem_word_v[i] = mem[rd_addr_v[i]];

    regfile_clr_rdport #(
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
      .REG_DATA_WIDTH(REG_DATA_WIDTH)
    ) u_rd (
      .rd_en   (rd_en_v[i]),
      .rd_addr (rd_addr_v[i]),
      .mem_word(mem_word_v[i]),
      .blank   (blank),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data_v[i])
    );
  end

endmodule
